scarv_cop_dispatch: RTL

//  Issue stage of the ISE coprocessor, downstream of scarv_cop_idecode.

---
 rtl/scarv_cop_dispatch_pkg.sv | 56 +++++
 rtl/scarv_cop_dispatch_if.sv | 57 +++++
 rtl/scarv_cop_dispatch_idecode.sv | 30 +++
 rtl/scarv_cop_dispatch.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/scarv_cop_dispatch_pkg.sv
// Shared codes, FSM states and decoded-field layout for the ISE coprocessor issue stage.
package scarv_cop_dispatch_pkg;

  localparam logic [6:0] COP_OPCODE = 7'h2B;
  localparam logic [2:0] PW_MAX     = 3'd4;

  typedef enum logic [2:0] {
    ICLASS_NONE      = 3'd0,
    ICLASS_PALU      = 3'd1,
    ICLASS_MP        = 3'd2,
    ICLASS_BITMAN    = 3'd3,
    ICLASS_LOADSTORE = 3'd4,
    ICLASS_RANDOM    = 3'd5,
    ICLASS_MOVE      = 3'd6,
    ICLASS_RSVD      = 3'd7
  } iclass_e;

  typedef enum logic [2:0] {
    STATUS_OK       = 3'd0,
    STATUS_ILLEGAL  = 3'd1,
    STATUS_TIMEOUT  = 3'd2,
    STATUS_FU_ERROR = 3'd3
  } status_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  typedef struct packed {
    iclass_e     iclass;
    logic [3:0]  subclass;
    logic [2:0]  pw;
    logic [3:0]  crs1;
    logic [3:0]  crs2;
    logic [3:0]  crs3;
    logic [3:0]  crd;
    logic [3:0]  crd1;
    logic [3:0]  crd2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] wb_h;
    logic [31:0] wb_b;
  } fu_fields_t;

  // Class 0 and the reserved code 7 are never enabled, whatever the mask says.
  function automatic logic class_enabled(input iclass_e iclass, input logic [6:0] mask);
    logic [7:0] mask_ext;
    mask_ext = {1'b0, mask};
    return (iclass != ICLASS_NONE) && mask_ext[iclass];
  endfunction

endpackage

// File: rtl/scarv_cop_dispatch_if.sv
// CPU-side and FU-side handshake bundles of the coprocessor issue stage.
// master = initiator of the request (CPU on the cpu bundle, dispatcher on the fu bundle).
interface scarv_cop_cpu_if;
  logic        cpu_insn_req;
  logic        cpu_insn_ack;
  logic [31:0] cpu_insn_enc;
  logic [31:0] cpu_rs1_val;
  logic        cpu_insn_rsp;
  logic        cpu_rsp_ack;
  logic [2:0]  cpu_rsp_status;
  logic        cpu_rsp_wen;
  logic [4:0]  cpu_rsp_rd;
  logic [31:0] cpu_rsp_result;

  modport master (
    output cpu_insn_req, cpu_insn_enc, cpu_rs1_val, cpu_rsp_ack,
    input  cpu_insn_ack, cpu_insn_rsp, cpu_rsp_status, cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_result
  );
  modport slave (
    input  cpu_insn_req, cpu_insn_enc, cpu_rs1_val, cpu_rsp_ack,
    output cpu_insn_ack, cpu_insn_rsp, cpu_rsp_status, cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_result
  );
endinterface

interface scarv_cop_fu_if;
  logic        fu_valid;
  logic        fu_ready;
  logic [2:0]  fu_class;
  logic [3:0]  fu_subclass;
  logic [2:0]  fu_pw;
  logic [3:0]  fu_crs1;
  logic [3:0]  fu_crs2;
  logic [3:0]  fu_crs3;
  logic [3:0]  fu_crd;
  logic [3:0]  fu_crd1;
  logic [3:0]  fu_crd2;
  logic [31:0] fu_imm;
  logic [31:0] fu_rs1_val;
  logic [31:0] fu_wb_h;
  logic [31:0] fu_wb_b;
  logic        fu_done;
  logic        fu_error;
  logic        fu_wen;
  logic [31:0] fu_result;
  logic        fu_abort;

  modport master (
    output fu_valid, fu_class, fu_subclass, fu_pw, fu_crs1, fu_crs2, fu_crs3,
           fu_crd, fu_crd1, fu_crd2, fu_imm, fu_rs1_val, fu_wb_h, fu_wb_b, fu_abort,
    input  fu_ready, fu_done, fu_error, fu_wen, fu_result
  );
  modport slave (
    input  fu_valid, fu_class, fu_subclass, fu_pw, fu_crs1, fu_crs2, fu_crs3,
           fu_crd, fu_crd1, fu_crd2, fu_imm, fu_rs1_val, fu_wb_h, fu_wb_b, fu_abort,
    output fu_ready, fu_done, fu_error, fu_wen, fu_result
  );
endinterface

// File: rtl/scarv_cop_dispatch_idecode.sv
// Combinational instruction decoder; fed from the latched instruction register.
// Layout: [31:30] imm hi | [29:27] pw | [26:23] subclass | [22:19] crs2 | [18:15] crs1 | [14:12] class | [11:7] rd | [6:0] opcode
module scarv_cop_idecode
  import scarv_cop_dispatch_pkg::*;
(
  input  logic [31:0] enc_i,
  output logic        exception_o,
  output fu_fields_t  fields_o
);

  always_comb begin
    fields_o          = '0;
    fields_o.iclass   = iclass_e'(enc_i[14:12]);
    fields_o.subclass = enc_i[26:23];
    fields_o.pw       = enc_i[29:27];
    fields_o.crs1     = enc_i[18:15];
    fields_o.crs2     = enc_i[22:19];
    // Accumulating ops read their destination, so crs3 aliases crd; crd1/crd2 name the even/odd pair.
    fields_o.crs3     = enc_i[10:7];
    fields_o.crd      = enc_i[10:7];
    fields_o.crd1     = {enc_i[10:8], 1'b0};
    fields_o.crd2     = {enc_i[10:8], 1'b1};
    fields_o.rd       = enc_i[11:7];
    fields_o.imm      = {{15{enc_i[31]}}, enc_i[31:15]};
    fields_o.wb_h     = {31'd0, enc_i[15]};
    fields_o.wb_b     = {30'd0, enc_i[16:15]};
    exception_o       = (enc_i[6:0] != COP_OPCODE) || (enc_i[29:27] > PW_MAX);
  end

endmodule

// File: rtl/scarv_cop_dispatch.sv
// Coprocessor issue stage: accept from CPU, decode, dispatch to FUs, wait for done or timeout, respond.
// Latency accept->rsp is 3 cycles for a single-cycle FU, 2 for illegal; fu_* fields hold while fu_valid & !fu_ready.
module scarv_cop_dispatch
  import scarv_cop_dispatch_pkg::*;
#(
  parameter logic [6:0]  FEATURE_MASK = 7'h7F,
  parameter int unsigned FU_TIMEOUT   = 255
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  scarv_cop_cpu_if.slave   cpu,
  scarv_cop_fu_if.master   fu
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(FU_TIMEOUT);

  state_e      state_q;
  logic        ack_q;
  logic [31:0] enc_q;
  logic [31:0] rs1_q;
  fu_fields_t  fld_q;
  logic        fu_valid_q;
  logic [7:0]  cnt_q;
  logic        abort_q;
  logic        rsp_q;
  status_e     status_q;
  logic        wen_q;
  logic [31:0] result_q;

  logic        dec_exc;
  fu_fields_t  dec_fld;
  logic        illegal;
  status_e     done_status;
  logic        done_wen;
  logic [31:0] done_result;

  scarv_cop_idecode u_idecode (
    .enc_i       (enc_q),
    .exception_o (dec_exc),
    .fields_o    (dec_fld)
  );

  always_comb begin
    illegal     = dec_exc || !class_enabled(dec_fld.iclass, FEATURE_MASK);
    done_status = fu.fu_error ? STATUS_FU_ERROR : STATUS_OK;
    done_wen    = fu.fu_wen && !fu.fu_error;
    done_result = fu.fu_error ? 32'd0 : fu.fu_result;
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q    <= ST_IDLE;
      ack_q      <= 1'b0;
      enc_q      <= '0;
      rs1_q      <= '0;
      fld_q      <= '0;
      fu_valid_q <= 1'b0;
      cnt_q      <= '0;
      abort_q    <= 1'b0;
      rsp_q      <= 1'b0;
      status_q   <= STATUS_OK;
      wen_q      <= 1'b0;
      result_q   <= '0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ack_q && cpu.cpu_insn_req) begin
            enc_q   <= cpu.cpu_insn_enc;
            rs1_q   <= cpu.cpu_rs1_val;
            ack_q   <= 1'b0;
            state_q <= ST_DECODE;
          end else begin
            ack_q <= 1'b1;
          end
        end
        ST_DECODE: begin
          fld_q <= dec_fld;
          if (illegal) begin
            status_q <= STATUS_ILLEGAL;
            wen_q    <= 1'b0;
            result_q <= '0;
            rsp_q    <= 1'b1;
            state_q  <= ST_RESP;
          end else begin
            fu_valid_q <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (fu.fu_ready) begin
            fu_valid_q <= 1'b0;
            cnt_q      <= '0;
            if (fu.fu_done) begin
              status_q <= done_status;
              wen_q    <= done_wen;
              result_q <= done_result;
              rsp_q    <= 1'b1;
              state_q  <= ST_RESP;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          // A completion arriving in the timeout cycle takes priority over the abort.
          if (fu.fu_done) begin
            status_q <= done_status;
            wen_q    <= done_wen;
            result_q <= done_result;
            rsp_q    <= 1'b1;
            state_q  <= ST_RESP;
          end else if (cnt_q == TIMEOUT_CNT) begin
            abort_q  <= 1'b1;
            status_q <= STATUS_TIMEOUT;
            wen_q    <= 1'b0;
            result_q <= '0;
            rsp_q    <= 1'b1;
            state_q  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (cpu.cpu_rsp_ack) begin
            rsp_q    <= 1'b0;
            status_q <= STATUS_OK;
            wen_q    <= 1'b0;
            result_q <= '0;
            ack_q    <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cpu.cpu_insn_ack   = ack_q;
  assign cpu.cpu_insn_rsp   = rsp_q;
  assign cpu.cpu_rsp_status = status_q;
  assign cpu.cpu_rsp_wen    = wen_q;
  assign cpu.cpu_rsp_rd     = fld_q.rd;
  assign cpu.cpu_rsp_result = result_q;

  assign fu.fu_valid    = fu_valid_q;
  assign fu.fu_class    = fld_q.iclass;
  assign fu.fu_subclass = fld_q.subclass;
  assign fu.fu_pw       = fld_q.pw;
  assign fu.fu_crs1     = fld_q.crs1;
  assign fu.fu_crs2     = fld_q.crs2;
  assign fu.fu_crs3     = fld_q.crs3;
  assign fu.fu_crd      = fld_q.crd;
  assign fu.fu_crd1     = fld_q.crd1;
  assign fu.fu_crd2     = fld_q.crd2;
  assign fu.fu_imm      = fld_q.imm;
  assign fu.fu_rs1_val  = rs1_q;
  assign fu.fu_wb_h     = fld_q.wb_h;
  assign fu.fu_wb_b     = fld_q.wb_b;
  assign fu.fu_abort    = abort_q;

endmodule
